// File: rtl/fp_result_collector.sv
// Result collector behind the FP mul/div unit: buffers {sel, flags, R} in a small FIFO
// for a valid/ready consumer, and keeps sticky exception status plus a drop counter.
module fp_result_collector #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          in_valid,
  input  logic [31:0]   R,
  input  logic          sel,
  input  logic          io_flag,
  input  logic          dz_flag,
  input  logic          of_flag,
  input  logic          uf_flag,
  input  logic          i_flag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [4:0]    out_flags,
  output logic          out_sel,
  output logic [CW-1:0] fifo_count,
  output logic [4:0]    sticky_flags,
  input  logic          sticky_clr,
  output logic [7:0]    drop_cnt,
  output logic          overflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [37:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    in_flags;
  logic [37:0]   head;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign in_flags = {io_flag, dz_flag, of_flag, uf_flag, i_flag};
  assign full     = (fifo_count == CW'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop      = out_valid & out_ready;
  assign push     = in_valid & (~full | pop);
  assign drop     = in_valid & ~push;

  // Head is masked while empty so stale storage never leaks onto the outputs.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head[31:0];
  assign out_flags = head[36:32];
  assign out_sel   = head[37];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel, in_flags, R};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      sticky_flags <= '0;
      drop_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);

      // New flags survive a coincident clear.
      sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | (in_valid ? in_flags : 5'b0);

      if (sticky_clr)                    drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      overflow_err <= drop;
    end
  end

endmodule
